y86_alu: RTL and testbench

64-bit integer ALU for the Y86-64 execute stage. Computes add, subtract, AND or XOR of two signed operands and derives overflow, sign and zero condition codes. Result and condition codes are registered: one-cycle latency, updated every clock. It feeds valE to the memory/write-back path and CC to the condition-code/branch logic.

---
 rtl/y86_alu_pkg.sv | 25 ++
 rtl/y86_alu_if.sv | 25 ++
 rtl/y86_alu_addsub.sv | 26 ++
 rtl/y86_alu.sv | 64 ++++++
 tb/tb_y86_alu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: shared constants for the Y86-64 execute-stage ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: word width, ALU function codes, condition-code bit indices, CC reset value.
package y86_alu_pkg;

  localparam int WORD_W = 64;

  // Function-select encoding carried on ALUfun.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fun_e;

  // Bit positions inside the 3-bit condition-code vector.
  localparam int CC_OF = 0;
  localparam int CC_SF = 1;
  localparam int CC_ZF = 2;

  // Reset CC matches a zero result: ZF set, SF and OF clear.
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu_if.sv
// y86_alu_if: operand/function inputs and registered result/flags of the execute-stage ALU.
// Latency: n/a (signal bundle only); result lags operands by one clock inside the ALU.
// Backpressure: none, no handshake; a new operation may be presented every cycle.
// Signals: ALUA/ALUB operands, ALUfun op select, valE result, CC = {ZF, SF, OF}.
interface y86_alu_if;

  logic [63:0] ALUA;
  logic [63:0] ALUB;
  logic [1:0]  ALUfun;
  logic [63:0] valE;
  logic [2:0]  CC;

  // Master: the decode/execute control that supplies operands and consumes results.
  modport master (
    output ALUA, ALUB, ALUfun,
    input  valE, CC
  );

  // Slave: the ALU itself.
  modport slave (
    input  ALUA, ALUB, ALUfun,
    output valE, CC
  );

endinterface

// File: rtl/y86_alu_addsub.sv
// y86_alu_addsub: 64-bit adder/subtractor producing the sum and the signed-overflow flag.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i operands; sub_i selects A - B; sum_o result mod 2^64; ovf_o signed overflow.
module y86_alu_addsub
  import y86_alu_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              sub_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              ovf_o
);

  logic [WORD_W-1:0] b_eff;

  // Subtraction is A + ~B + 1; the carry-in rides on the low bit of the third addend.
  assign b_eff = sub_i ? ~b_i : b_i;
  assign sum_o = a_i + b_eff + {{(WORD_W-1){1'b0}}, sub_i};

  // Overflow when both addends share a sign that the sum does not. Using the
  // inverted B makes this one test cover both add and sub.
  assign ovf_o = (a_i[WORD_W-1] == b_eff[WORD_W-1]) &&
                 (sum_o[WORD_W-1] != a_i[WORD_W-1]);

endmodule

// File: rtl/y86_alu.sv
// y86_alu: Y86-64 execute-stage ALU (add/sub/and/xor) with OF/SF/ZF condition codes.
// Latency: 1 clock; valE and CC are registered and update on every rising edge.
// Backpressure: none; accepts a new operation every cycle, rst loads valE=0, CC=3'b100.
// Ports: clk, rst (sync, active high), alu (slave modport: ALUA, ALUB, ALUfun in; valE, CC out).
module y86_alu
  import y86_alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  y86_alu_if.slave  alu
);

  logic [WORD_W-1:0] sum;
  logic              ovf;
  logic [WORD_W-1:0] val_e_d;
  logic [WORD_W-1:0] val_e_q;
  logic              of_d;
  logic [2:0]        cc_d;
  logic [2:0]        cc_q;

  y86_alu_addsub u_addsub (
    .a_i   (alu.ALUA),
    .b_i   (alu.ALUB),
    .sub_i (alu.ALUfun == ALU_SUB),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  always_comb begin
    val_e_d = sum;
    of_d    = 1'b0;
    case (alu.ALUfun)
      ALU_ADD,
      ALU_SUB: begin
        val_e_d = sum;
        of_d    = ovf;
      end
      ALU_AND: val_e_d = alu.ALUA & alu.ALUB;
      ALU_XOR: val_e_d = alu.ALUA ^ alu.ALUB;
      default: ;
    endcase
  end

  always_comb begin
    cc_d        = '0;
    cc_d[CC_OF] = of_d;
    cc_d[CC_SF] = val_e_d[WORD_W-1];
    cc_d[CC_ZF] = (val_e_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_e_q <= '0;
      cc_q    <= CC_RESET;
    end else begin
      val_e_q <= val_e_d;
      cc_q    <= cc_d;
    end
  end

  assign alu.valE = val_e_q;
  assign alu.CC   = cc_q;

endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: self-checking bench for y86_alu using an expected-result queue.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: none; operations are issued every cycle.
module tb_y86_alu;

  typedef struct {
    logic [63:0] v;
    logic [2:0]  cc;
  } exp_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  f;
    logic [63:0] v;
    logic [2:0]  cc;
  } vec_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   checks;
  int   failures;

  y86_alu_if alu_if ();

  y86_alu u_dut (
    .clk (clk),
    .rst (rst),
    .alu (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: 65-bit signed arithmetic, overflow when the result
  // does not fit in 64 bits.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f);
    exp_t        e;
    logic [64:0] w;
    logic        of;
    of = 1'b0;
    w  = '0;
    case (f)
      2'b00: begin w = {a[63], a} + {b[63], b}; of = w[64] ^ w[63]; e.v = w[63:0]; end
      2'b01: begin w = {a[63], a} - {b[63], b}; of = w[64] ^ w[63]; e.v = w[63:0]; end
      2'b10: e.v = a & b;
      default: e.v = a ^ b;
    endcase
    e.cc = {(e.v == 64'd0), e.v[63], of};
    return e;
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue what should appear after the next rising edge.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                       input logic r, input logic [63:0] ev, input logic [2:0] ecc);
    exp_t e;
    @(negedge clk);
    alu_if.ALUA   = a;
    alu_if.ALUB   = b;
    alu_if.ALUfun = f;
    rst           = r;
    e.v  = ev;
    e.cc = ecc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2)
        drive({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'b1, 64'd0, 3'b100);
      else
        drive(64'd45, 64'd38, 2'b00, 1'b0, 64'd83, 3'b000);
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL reset_sb_empty step=%0d", i);
      end else begin
        e = sb.pop_front();
        if (alu_if.valE !== e.v || alu_if.CC !== e.cc) begin
          failures++;
          $display("FAIL reset step=%0d valE=%h CC=%b expected valE=%h CC=%b", i, alu_if.valE, alu_if.CC, e.v, e.cc);
        end
      end
    end
  endtask

  task automatic test_arith();
    vec_t tbl[12];
    exp_t e;
    tbl = '{
      '{64'd45,    64'd38,    2'b00, 64'd83,    3'b000},
      '{64'd45,    64'd38,    2'b01, 64'd7,     3'b000},
      '{64'd45,    64'd38,    2'b10, 64'd36,    3'b000},
      '{64'd45,    64'd38,    2'b11, 64'd11,    3'b000},
      '{-64'sd45,  64'd38,    2'b00, -64'sd7,   3'b010},
      '{-64'sd45,  64'd38,    2'b01, -64'sd83,  3'b010},
      '{-64'sd45,  64'd38,    2'b10, 64'd2,     3'b000},
      '{-64'sd45,  64'd38,    2'b11, -64'sd11,  3'b010},
      '{-64'sd45,  -64'sd38,  2'b00, -64'sd83,  3'b010},
      '{-64'sd45,  -64'sd38,  2'b01, -64'sd7,   3'b010},
      '{-64'sd45,  -64'sd38,  2'b10, -64'sd46,  3'b010},
      '{-64'sd45,  -64'sd38,  2'b11, 64'd9,     3'b000}
    };
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].f, 1'b0, tbl[i].v, tbl[i].cc);
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL arith_sb_empty idx=%0d", i);
      end else begin
        e = sb.pop_front();
        if (alu_if.valE !== e.v || alu_if.CC !== e.cc) begin
          failures++;
          $display("FAIL arith idx=%0d valE=%h CC=%b expected valE=%h CC=%b", i, alu_if.valE, alu_if.CC, e.v, e.cc);
        end
      end
    end
  endtask

  task automatic test_overflow_zero();
    vec_t tbl[5];
    exp_t e;
    tbl = '{
      '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  2'b00, 64'h8000_0000_0000_0000, 3'b011},
      '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h8000_0000_0000_0000, 3'b011},
      '{64'h8000_0000_0000_0000, 64'd1,                  2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001},
      '{64'd123,                 64'd123,                2'b01, 64'd0,                  3'b100},
      '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'd0,                  3'b100}
    };
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].f, 1'b0, tbl[i].v, tbl[i].cc);
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL ovf_zero_sb_empty idx=%0d", i);
      end else begin
        e = sb.pop_front();
        if (alu_if.valE !== e.v || alu_if.CC !== e.cc) begin
          failures++;
          $display("FAIL ovf_zero idx=%0d valE=%h CC=%b expected valE=%h CC=%b", i, alu_if.valE, alu_if.CC, e.v, e.cc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  f;
    exp_t        m;
    exp_t        e;
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      // Bias some operands toward the sign boundary and toward equality.
      if (i % 7 == 0) a = {1'b0, {63{1'b1}}} - 64'($urandom_range(0, 3));
      if (i % 11 == 0) b = a;
      f = 2'($urandom_range(0, 3));
      m = model(a, b, f);
      drive(a, b, f, 1'b0, m.v, m.cc);
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL b2b_sb_empty idx=%0d", i);
      end else begin
        e = sb.pop_front();
        if (alu_if.valE !== e.v || alu_if.CC !== e.cc) begin
          failures++;
          $display("FAIL b2b idx=%0d f=%b valE=%h CC=%b expected valE=%h CC=%b", i, f, alu_if.valE, alu_if.CC, e.v, e.cc);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    vec_t tbl[4];
    logic r;
    exp_t e;
    tbl = '{
      '{64'd100,   64'd1,    2'b00, 64'd101, 3'b000},
      '{-64'sd5,   64'd3,    2'b00, 64'd0,   3'b100},
      '{64'd9,     64'd10,   2'b01, -64'sd1, 3'b010},
      '{64'd12,    64'd10,   2'b10, 64'd8,   3'b000}
    };
    for (int i = 0; i < 4; i++) begin
      r = (i == 1);
      drive(tbl[i].a, tbl[i].b, tbl[i].f, r, tbl[i].v, tbl[i].cc);
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL mid_reset_sb_empty idx=%0d", i);
      end else begin
        e = sb.pop_front();
        if (alu_if.valE !== e.v || alu_if.CC !== e.cc) begin
          failures++;
          $display("FAIL mid_reset idx=%0d valE=%h CC=%b expected valE=%h CC=%b", i, alu_if.valE, alu_if.CC, e.v, e.cc);
        end
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    alu_if.ALUA   = '0;
    alu_if.ALUB   = '0;
    alu_if.ALUfun = 2'b00;
    test_reset();
    test_arith();
    test_overflow_zero();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover entries=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
